// File: rtl/sum_acc_pkg.sv
// Shared constants and types for the sum accumulator / decumulator link.
// Default widths live here so both ends of the link agree on them.
package sum_acc_pkg;

    localparam int SA_NB_DATA_IN  = 3;
    localparam int SA_NB_DATA_OUT = 6;
    localparam int SA_NB_DELTA    = SA_NB_DATA_IN + 1;
    localparam int SA_NB_CNT      = 8;

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Largest step the accumulator can take: two full-scale operands.
    function automatic int max_inc(input int nb_data_in);
        return 2 * ((1 << nb_data_in) - 1);
    endfunction

    typedef struct packed {
        logic [SA_NB_DELTA-1:0] delta;
        logic                   wrap;
        logic                   err;
    } delta_t;

endpackage

// File: rtl/sum_delta_reg.sv
// Single-entry valid/ready output register with synchronous flush.
// The producer only loads when the entry is free or being consumed this cycle.
module sum_delta_reg
    import sum_acc_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_flush,
    input  logic   i_load,
    input  delta_t i_data,
    input  logic   i_ready,
    output logic   o_valid,
    output delta_t o_data
);

    logic   valid_q, valid_d;
    delta_t data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/sum_decumulator.sv
// Recovers per-cycle increments from an accumulator's running sum stream,
// checks them against the accumulator's wrap/step rules and halts on a bad one.
module sum_decumulator
    import sum_acc_pkg::*;
#(
    parameter int NB_DATA_IN  = SA_NB_DATA_IN,
    parameter int NB_DATA_OUT = SA_NB_DATA_OUT,
    parameter int NB_DELTA    = NB_DATA_IN + 1,
    parameter int NB_CNT      = SA_NB_CNT
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [NB_DATA_OUT-1:0] i_data,
    input  logic                   i_overflow,
    output logic                   o_ready,
    input  logic                   i_resync,
    output logic                   o_valid,
    output logic [NB_DELTA-1:0]    o_delta,
    output logic                   o_wrap,
    output logic                   o_err,
    input  logic                   i_ready,
    output logic                   o_halted,
    output logic [NB_CNT-1:0]      o_count
);

    localparam logic [NB_DATA_OUT-1:0] MAX_INC_W = NB_DATA_OUT'(max_inc(NB_DATA_IN));

    state_t                 state_q;
    logic [NB_DATA_OUT-1:0] prev_q;
    logic [NB_CNT-1:0]      cnt_q;

    logic                   accept;
    logic                   load;
    logic                   out_hs;
    logic [NB_DATA_OUT-1:0] diff;
    logic                   wrap;
    logic                   err;
    delta_t                 delta_d;
    delta_t                 out_q;
    logic                   out_valid;

    // Modular difference; the accumulator only wraps when the sum goes down.
    assign diff = i_data - prev_q;
    assign wrap = (i_data < prev_q);
    assign err  = (diff > MAX_INC_W) | (i_overflow != wrap);

    assign delta_d.delta = diff[NB_DELTA-1:0];
    assign delta_d.wrap  = wrap;
    assign delta_d.err   = err;

    // HALT drains the input so the upstream never stalls on a dead link.
    assign o_ready = (state_q == ST_HALT) | ~out_valid | i_ready;
    assign accept  = i_valid & o_ready;
    assign load    = accept & (state_q == ST_RUN) & ~i_resync;
    assign out_hs  = out_valid & i_ready & ~out_q.err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_PRIME;
            prev_q  <= '0;
            cnt_q   <= '0;
        end else if (i_resync) begin
            state_q <= ST_PRIME;
            cnt_q   <= '0;
        end else begin
            if (out_hs && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
            if (accept) begin
                case (state_q)
                    ST_PRIME: begin
                        prev_q  <= i_data;
                        state_q <= ST_RUN;
                    end
                    ST_RUN: begin
                        prev_q <= i_data;
                        if (err)
                            state_q <= ST_HALT;
                    end
                    default: ;
                endcase
            end
        end
    end

    sum_delta_reg u_out (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_resync),
        .i_load  (load),
        .i_data  (delta_d),
        .i_ready (i_ready),
        .o_valid (out_valid),
        .o_data  (out_q)
    );

    assign o_valid  = out_valid;
    assign o_delta  = out_q.delta;
    assign o_wrap   = out_q.wrap;
    assign o_err    = out_q.err;
    assign o_halted = (state_q == ST_HALT);
    assign o_count  = cnt_q;

endmodule

// File: tb/tb_sum_decumulator.sv
// Directed plus random stimulus for sum_decumulator against a sample-level
// reference model (modular difference of consecutive accepted samples).
module tb_sum_decumulator;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_valid = 1'b0;
    logic [5:0] i_data = '0;
    logic       i_overflow = 1'b0;
    logic       i_resync = 1'b0;
    logic       i_ready = 1'b0;
    logic       o_ready, o_valid, o_wrap, o_err, o_halted;
    logic [3:0] o_delta;
    logic [7:0] o_count;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 priming, 1 running, 2 halted.
    int m_mode = 0, m_prev = 0, m_pv = 0, m_d = 0, m_w = 0, m_e = 0, m_cnt = 0;

    sum_decumulator dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
        .i_overflow(i_overflow), .o_ready(o_ready), .i_resync(i_resync),
        .o_valid(o_valid), .o_delta(o_delta), .o_wrap(o_wrap), .o_err(o_err),
        .i_ready(i_ready), .o_halted(o_halted), .o_count(o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready(input bit rdy);
        return (m_mode == 2) || (m_pv == 0) || rdy;
    endfunction

    task automatic step(input bit v, input int d, input bit ovf, input bit rs,
                        input bit rdy, output bit acc);
        bit cons, ld, w, e;
        int diff;
        @(negedge clk);
        i_rst = 1'b0; i_valid = v; i_data = d[5:0]; i_overflow = ovf;
        i_resync = rs; i_ready = rdy;
        #1 chk("o_ready", o_ready, m_ready(rdy));
        acc = v && m_ready(rdy);
        if (rs) begin
            m_mode = 0; m_pv = 0; m_cnt = 0;
        end else begin
            cons = (m_pv != 0) && rdy;
            ld = 1'b0;
            if (cons && m_e == 0 && m_cnt < 255) m_cnt++;
            if (acc && m_mode == 0) begin
                m_prev = d; m_mode = 1;
            end else if (acc && m_mode == 1) begin
                diff = (d - m_prev + 64) % 64;
                w = d < m_prev;
                e = (diff > 14) || (ovf != w);
                m_d = diff % 16; m_w = w; m_e = e; ld = 1'b1;
                m_prev = d;
                if (e) m_mode = 2;
            end
            if (ld) m_pv = 1; else if (cons) m_pv = 0;
        end
        @(posedge clk); #1;
        chk("o_valid", o_valid, m_pv);
        chk("o_halted", o_halted, m_mode == 2);
        chk("o_count", o_count, m_cnt);
        if (m_pv != 0) begin
            chk("o_delta", o_delta, m_d);
            chk("o_wrap", o_wrap, m_w);
            chk("o_err", o_err, m_e);
        end
    endtask

    task automatic s(input bit v, input int d, input bit ovf, input bit rs, input bit rdy);
        bit acc;
        step(v, d, ovf, rs, rdy, acc);
    endtask

    task automatic do_reset(input bit rs);
        @(negedge clk);
        i_rst = 1'b1; i_valid = 1'b1; i_data = 6'd33; i_resync = rs; i_ready = 1'b0;
        m_mode = 0; m_prev = 0; m_pv = 0; m_cnt = 0; m_e = 0;
        @(posedge clk); #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_delta", o_delta, 0);
        chk("rst_wrap", o_wrap, 0);
        chk("rst_err", o_err, 0);
        chk("rst_halted", o_halted, 0);
        chk("rst_count", o_count, 0);
        chk("rst_ready", o_ready, 1);
    endtask

    initial begin
        int last, d;
        bit v, rdy, rs, ovf, acc;

        do_reset(1'b0);

        // Prime then 0 -> 5 -> 19
        s(1, 0, 0, 0, 1);
        s(1, 5, 0, 0, 1);  chk("d5", o_delta, 5);
        s(1, 19, 0, 0, 1); chk("d14", o_delta, 14); chk("d14_err", o_err, 0);
        s(0, 0, 0, 0, 1);  chk("cnt2", o_count, 2);

        // Legal wrap 60 -> 2
        s(0, 0, 0, 1, 1);
        s(1, 60, 0, 0, 1);
        s(1, 2, 1, 0, 1);  chk("wrap_d", o_delta, 6); chk("wrap_w", o_wrap, 1);
        chk("wrap_err", o_err, 0);

        // Oversized step halts; resync recovers
        s(0, 0, 0, 1, 1);
        s(1, 10, 0, 0, 1);
        s(1, 26, 0, 0, 1); chk("big_err", o_err, 1); chk("big_halt", o_halted, 1);
        s(1, 30, 0, 0, 1); chk("halt_drop", o_valid, 0);
        s(0, 0, 0, 1, 1);
        s(1, 30, 0, 0, 1);
        s(1, 33, 0, 0, 1); chk("resync_d3", o_delta, 3);

        // Wrap without overflow flag
        s(0, 0, 0, 1, 1);
        s(1, 60, 0, 0, 1);
        s(1, 2, 0, 0, 1);  chk("wrapmis_err", o_err, 1);
        s(0, 0, 0, 0, 1);  chk("wrapmis_halt", o_halted, 1);

        // Backpressure: stream 1,2,3 with i_ready low for 4 cycles
        s(0, 0, 0, 1, 1);
        s(1, 0, 0, 0, 1);
        s(1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) s(1, 2, 0, 0, 0);
        chk("stall_hold", o_delta, 1);
        s(1, 2, 0, 0, 1);  chk("stall_d2", o_delta, 1);
        s(1, 3, 0, 0, 1);  chk("stall_d3", o_delta, 1);

        // Resync with an accepted sample while output pending
        s(1, 4, 0, 0, 0);
        s(1, 5, 0, 1, 1);  chk("rs_valid", o_valid, 0); chk("rs_cnt", o_count, 0);
        s(1, 9, 0, 0, 1);  chk("rs_prime", o_valid, 0);
        s(1, 10, 0, 0, 1); chk("rs_d1", o_delta, 1);

        // Reset mid-stream with pending output, valid and resync asserted
        s(1, 20, 0, 0, 0);
        do_reset(1'b1);

        // Counter saturation
        s(1, 0, 0, 0, 1);
        for (int k = 1; k <= 270; k++) s(1, k % 64, (k % 64) == 0, 0, 1);
        s(0, 0, 0, 0, 1);  chk("cnt_sat", o_count, 255);

        // Random traffic
        s(0, 0, 0, 1, 1);
        last = 0;
        for (int n = 0; n < 400; n++) begin
            v   = $urandom_range(0, 3) != 0;
            rdy = $urandom_range(0, 3) != 0;
            rs  = (m_mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) begin
                d   = $urandom_range(0, 63);
                ovf = $urandom_range(0, 1);
            end else begin
                d   = (last + $urandom_range(0, 14)) % 64;
                ovf = d < last;
            end
            step(v, d, ovf, rs, rdy, acc);
            if (acc) last = d;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sum_decumulator.md
# sum_decumulator

Streaming differentiator that reverses the sum accumulator. It accepts the accumulator's registered running sum and overflow flag as a valid/ready stream and recovers each per-cycle increment as a modular difference against the previous sample. It checks every recovered increment against the accumulator's wrap behaviour and maximum step size, and halts on inconsistency. The block sits on the read side of an accumulator link, feeding checkers or downstream consumers.

## Interface
- NB_DATA_IN, 3, operand width at the accumulator input; max increment = 2*(2^NB_DATA_IN - 1) = 14
- NB_DATA_OUT, 6, accumulated sum width (sample width here)
- NB_DELTA, NB_DATA_IN+1, recovered increment width
- NB_CNT, 8, width of the emitted-delta counter
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  input sample valid
- i_data  in  NB_DATA_OUT  accumulated sum sample
- i_overflow  in  1  accumulator overflow flag paired with i_data
- o_ready  out  1  input accepted when i_valid & o_ready
- i_resync  in  1  single-cycle request to discard history and re-prime
- o_valid  out  1  output delta valid
- o_delta  out  NB_DELTA  recovered increment
- o_wrap  out  1  sample wrapped modulo 2^NB_DATA_OUT
- o_err  out  1  increment inconsistent; qualifies o_valid
- i_ready  in  1  downstream accepts when o_valid & i_ready
- o_halted  out  1  FSM in HALT
- o_count  out  NB_CNT  emitted deltas since prime, saturating at all-ones

## Operation
- FSM states: PRIME, RUN, HALT. Reset state is PRIME.
- **PRIME.** An accepted sample loads prev_q <= i_data. No output is produced. Next state is RUN.
- **RUN.** For an accepted sample:
  - diff = (i_data - prev_q) mod 2^NB_DATA_OUT, computed at NB_DATA_OUT width.
  - wrap = (i_data < prev_q).
  - err = (diff > MAX_INC) | (i_overflow != wrap).
  - Load the output register: o_delta <= diff[NB_DELTA-1:0], o_wrap <= wrap, o_err <= err, o_valid <= 1.
  - prev_q <= i_data.
  - If err, next state is HALT. Otherwise stay in RUN.
- **HALT.** o_ready = 1. Accepted samples are discarded and produce no output. The block stays in HALT until i_resync. An errored delta already in the output register is still delivered.
- **i_resync** in any state:
  - Next state is PRIME, o_valid <= 0 (a pending delta is dropped), o_count <= 0.
  - A sample accepted in the same cycle is dropped.
  - Resync has priority over every other event.
- **Output register** is a single entry: o_ready = ~o_valid | i_ready in PRIME and RUN.
  - Simultaneous output consume and input accept: the register reloads, o_valid stays 1.
  - Consume without a new accept: o_valid <= 0.
- **o_count** increments on each output handshake with o_err = 0. It saturates at 2^NB_CNT - 1.
- **Zero increment:** diff = 0 is legal, giving o_delta = 0, o_wrap = 0.

## Timing
- Reset values: o_valid 0, o_delta 0, o_wrap 0, o_err 0, o_halted 0, o_count 0, o_ready 1. prev_q is cleared to 0.
- Latency: an accepted RUN sample appears on the outputs on the next cycle.
- Throughput: one delta per cycle while i_ready = 1.
- o_ready is combinational from o_valid and i_ready. No other input-to-output combinational path exists.
- Output stability: o_delta, o_wrap and o_err hold while o_valid & ~i_ready.
- o_halted is registered and asserts the cycle after the errored sample is accepted.
- Reset asserted mid-stream returns all state to reset values on the next edge, regardless of i_valid or i_resync.

## Structure
- A shared package `sum_acc_pkg` holds:
  - the FSM state enum type (PRIME/RUN/HALT);
  - the MAX_INC function of NB_DATA_IN;
  - a delta struct {delta, wrap, err}.
- The accumulator block shares the same package for its width constants.
- One sub-module, `sum_delta_reg`: the single-entry valid/ready output register with synchronous flush. The top level keeps the FSM, prev_q, the difference/check datapath and the counter.

## Test plan
- Prime, then samples 0→5→19 with i_overflow = 0 and i_ready = 1. Expect deltas 5 and 14, o_wrap = 0, o_err = 0, o_count = 2, one-cycle latency.
- Samples 60→2 with i_overflow = 1. Expect o_delta = 6, o_wrap = 1, o_err = 0.
- Samples 10→26 (diff 16 > 14). Expect o_err = 1 delivered, then o_halted = 1. A following sample 30 gives no output. i_resync then samples 30→33 gives delta 3.
- Samples 60→2 with i_overflow = 0. Expect o_err = 1 (wrap mismatch), then HALT.
- Hold i_ready = 0 for 4 cycles with a stream 1,2,3. Expect o_ready = 0 after the first delta, o_delta = 1 held stable, no sample loss when i_ready returns.
- Assert i_resync together with an accepted sample while o_valid = 1. Expect o_valid = 0 next cycle, the sample dropped, state PRIME, o_count = 0. Assert i_rst mid-stream: all outputs return to reset values.
